// File: rtl/shift_reg_rs_pkg.sv
// shift_reg_rs_pkg: mode encodings shared by the register and its bench
package shift_reg_rs_pkg;
    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_CNTUP = 3'b110;
    localparam logic [2:0] MODE_CNTDN = 3'b111;
endpackage

// File: rtl/shift_reg_rs_dff_en_rs.sv
// dff_en_rs: 1-bit flop with sync reset > set > enable, per-bit reset/set values
module dff_en_rs #(
    parameter logic RESET_VALUE = 1'b0,
    parameter logic SET_VALUE   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic en,
    input  logic d_i,
    output logic q_o
);
    always_ff @(posedge clk)
        q_o <= reset ? RESET_VALUE : set ? SET_VALUE : en ? d_i : q_o;
endmodule

// File: rtl/shift_reg_rs.sv
// shift_reg_rs: WIDTH-bit register with sync reset/set, enable and
// hold/load/shift/rotate/count modes; co pulses on a count wrap
module shift_reg_rs
    import shift_reg_rs_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VALUE   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             co
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             co_q, co_d;
    always_comb begin
        case (mode)
            MODE_LOAD:  q_d = d;
            MODE_SHL:   q_d = {q_q[WIDTH-2:0], si};
            MODE_SHR:   q_d = {si, q_q[WIDTH-1:1]};
            MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_CNTUP: q_d = q_q + WIDTH'(1);
            MODE_CNTDN: q_d = q_q - WIDTH'(1);
            default:    q_d = q_q;
        endcase
    end
    // wrap is detected on the pre-edge value so co lines up with the wrapped q
    assign co_d = en & ((mode == MODE_CNTUP & (&q_q)) | (mode == MODE_CNTDN & ~(|q_q)));
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_en_rs #(
            .RESET_VALUE(RESET_VALUE[i]),
            .SET_VALUE  (SET_VALUE[i])
        ) u_bit (
            .clk  (clk),
            .reset(reset),
            .set  (set),
            .en   (en),
            .d_i  (q_d[i]),
            .q_o  (q_q[i])
        );
    end
    always_ff @(posedge clk)
        co_q <= (reset | set) ? 1'b0 : co_d;
    assign q      = q_q;
    assign so_msb = q_q[WIDTH-1];
    assign so_lsb = q_q[0];
    assign co     = co_q;
endmodule

// File: tb/tb_shift_reg_rs.sv
// tb_shift_reg_rs: directed vectors push expectations into a queue; a monitor
// pops one per clock edge and checks q, co, so_msb and so_lsb
module tb_shift_reg_rs;
    import shift_reg_rs_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0, set = 1'b0, en = 1'b0, si = 1'b0;
    logic [2:0] mode = MODE_HOLD;
    logic [7:0] d = 8'h00;
    logic [7:0] q;
    logic       so_msb, so_lsb, co;

    typedef struct packed {
        logic [7:0] q;
        logic       co;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    shift_reg_rs dut (
        .clk   (clk),
        .reset (reset),
        .set   (set),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .si    (si),
        .q     (q),
        .so_msb(so_msb),
        .so_lsb(so_lsb),
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("q", q, e.q);
            check("co", {7'b0, co}, {7'b0, e.co});
            check("so_msb", {7'b0, so_msb}, {7'b0, e.q[7]});
            check("so_lsb", {7'b0, so_lsb}, {7'b0, e.q[0]});
        end
    end

    task automatic step(input logic r, input logic s, input logic e, input logic [2:0] m,
                        input logic [7:0] dd, input logic sii,
                        input logic [7:0] eq, input logic ec);
        @(negedge clk);
        reset = r; set = s; en = e; mode = m; d = dd; si = sii;
        exp_q.push_back('{q: eq, co: ec});
    endtask

    initial begin
        step(1, 1, 1, MODE_LOAD,  8'h3C, 0, 8'h00, 0);
        step(0, 1, 1, MODE_LOAD,  8'h3C, 0, 8'hFF, 0);
        step(0, 0, 1, MODE_LOAD,  8'hA5, 0, 8'hA5, 0);
        step(0, 0, 0, MODE_SHL,   8'h00, 1, 8'hA5, 0);
        step(0, 0, 0, MODE_SHL,   8'h00, 0, 8'hA5, 0);
        step(0, 0, 0, MODE_SHL,   8'h00, 1, 8'hA5, 0);
        step(0, 0, 1, MODE_SHL,   8'h00, 1, 8'h4B, 0);
        step(0, 0, 1, MODE_SHR,   8'h00, 0, 8'h25, 0);
        step(0, 0, 1, MODE_SHR,   8'h00, 1, 8'h92, 0);
        step(0, 0, 1, MODE_HOLD,  8'h00, 1, 8'h92, 0);
        step(0, 0, 1, MODE_LOAD,  8'hA5, 0, 8'hA5, 0);
        step(0, 0, 1, MODE_ROR,   8'h00, 1, 8'hD2, 0);
        step(0, 0, 1, MODE_ROL,   8'h00, 0, 8'hA5, 0);
        step(0, 0, 1, MODE_ROL,   8'h00, 0, 8'h4B, 0);
        step(0, 0, 1, MODE_LOAD,  8'hFE, 0, 8'hFE, 0);
        step(0, 0, 1, MODE_CNTUP, 8'h00, 0, 8'hFF, 0);
        step(0, 0, 1, MODE_CNTUP, 8'h00, 1, 8'h00, 1);
        step(0, 0, 1, MODE_CNTUP, 8'h00, 0, 8'h01, 0);
        step(0, 0, 1, MODE_CNTDN, 8'h00, 0, 8'h00, 0);
        step(0, 0, 1, MODE_CNTDN, 8'h00, 0, 8'hFF, 1);
        step(0, 0, 0, MODE_CNTUP, 8'h00, 0, 8'hFF, 0);
        step(0, 1, 1, MODE_CNTUP, 8'h00, 0, 8'hFF, 0);
        step(0, 0, 1, MODE_LOAD,  8'h00, 0, 8'h00, 0);
        step(0, 0, 0, MODE_CNTDN, 8'h00, 0, 8'h00, 0);
        step(0, 0, 1, MODE_LOAD,  8'h10, 0, 8'h10, 0);
        step(0, 0, 1, MODE_CNTUP, 8'h00, 0, 8'h11, 0);
        step(1, 0, 1, MODE_CNTUP, 8'h00, 0, 8'h00, 0);
        step(0, 0, 1, MODE_CNTUP, 8'h00, 0, 8'h01, 0);
        step(0, 0, 1, MODE_CNTUP, 8'h00, 0, 8'h02, 0);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
